normalize_shift_iter: RTL and testbench

NORMALIZE_SHIFT_ITER -- requirements
Module: normalize_shift_iter

---
 rtl/normalize_shift_iter_if.sv | 27 ++
 rtl/normalize_shift_iter.sv | 134 +++++++++++++
 tb/tb_normalize_shift_iter.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/normalize_shift_iter_if.sv
// rtl/normalize_shift_iter_if.sv - request/result handshake bundle for normalize_shift_iter
interface normalize_shift_iter_if #(
    parameter int WIDTH = 32,
    parameter int CW    = $clog2(WIDTH + 1)
) ();
    logic             start;
    logic             mode;
    logic [WIDTH-1:0] a;
    logic             in_ready;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] value;
    logic [CW-1:0]    shift_cnt;
    logic             dir_left;
    logic             zero;
    logic             sticky;

    modport master (
        output start, mode, a, out_ready,
        input  in_ready, out_valid, value, shift_cnt, dir_left, zero, sticky
    );

    modport slave (
        input  start, mode, a, out_ready,
        output in_ready, out_valid, value, shift_cnt, dir_left, zero, sticky
    );
endinterface

// File: rtl/normalize_shift_iter.sv
// rtl/normalize_shift_iter.sv - iterative one-bit-per-cycle normalizer into bits FIELD-1..0
// Optional sticky tracking of right-shifted-out bits is enabled by macro NORM_STICKY_EN.
module normalize_shift_iter #(
    parameter int WIDTH = 32,
    parameter int FIELD = 24
) (
    input  logic                    clk,
    input  logic                    rst,
    normalize_shift_iter_if.slave   bus
);
    localparam int CW = $clog2(WIDTH + 1);
    // Ones in bits FIELD-1..0; anything outside must be shifted right.
    localparam logic [WIDTH-1:0] LO_MASK = {WIDTH{1'b1}} >> (WIDTH - FIELD);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] value_q, value_d;
    logic [CW-1:0]    shift_cnt_q, shift_cnt_d;
    logic             dir_left_q, dir_left_d;
    logic             zero_q, zero_d;
    logic             mode_q, mode_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic             right_cond;
    logic             left_cond;

    assign right_cond = |(value_q & ~LO_MASK);
    assign left_cond  = mode_q && (value_q != '0) && !value_q[FIELD-1] && !right_cond;

    always_comb begin
        state_d     = state_q;
        value_d     = value_q;
        shift_cnt_d = shift_cnt_q;
        dir_left_d  = dir_left_q;
        zero_d      = zero_q;
        mode_d      = mode_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    value_d     = bus.a;
                    shift_cnt_d = '0;
                    dir_left_d  = 1'b0;
                    zero_d      = (bus.a == '0);
                    mode_d      = bus.mode;
                    state_d     = SHIFT;
                    in_ready_d  = 1'b0;
                end
            end
            SHIFT: begin
                // Right shifts take precedence, so left shifts only ever follow a fitting value.
                if (right_cond) begin
                    value_d     = value_q >> 1;
                    shift_cnt_d = shift_cnt_q + 1'b1;
                end else if (left_cond) begin
                    value_d     = value_q << 1;
                    shift_cnt_d = shift_cnt_q + 1'b1;
                    dir_left_d  = 1'b1;
                end else begin
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                end
            end
            default: begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            value_q     <= '0;
            shift_cnt_q <= '0;
            dir_left_q  <= 1'b0;
            zero_q      <= 1'b0;
            mode_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            value_q     <= value_d;
            shift_cnt_q <= shift_cnt_d;
            dir_left_q  <= dir_left_d;
            zero_q      <= zero_d;
            mode_q      <= mode_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

`ifdef NORM_STICKY_EN
    logic sticky_q, sticky_d;

    always_comb begin
        sticky_d = sticky_q;
        if (state_q == IDLE && bus.start) begin
            sticky_d = 1'b0;
        end else if (state_q == SHIFT && right_cond) begin
            sticky_d = sticky_q | value_q[0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sticky_q <= 1'b0;
        end else begin
            sticky_q <= sticky_d;
        end
    end

    assign bus.sticky = sticky_q;
`else
    assign bus.sticky = 1'b0;
`endif

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.value     = value_q;
    assign bus.shift_cnt = shift_cnt_q;
    assign bus.dir_left  = dir_left_q;
    assign bus.zero      = zero_q;
endmodule

// File: tb/tb_normalize_shift_iter.sv
// tb/tb_normalize_shift_iter.sv - self-checking bench for normalize_shift_iter (WIDTH=32, FIELD=24)
module tb_normalize_shift_iter;
    localparam int WIDTH = 32;
    localparam int FIELD = 24;
    localparam int CW    = $clog2(WIDTH + 1);

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    normalize_shift_iter_if #(.WIDTH(WIDTH), .CW(CW)) bus ();

    normalize_shift_iter #(.WIDTH(WIDTH), .FIELD(FIELD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: locate the leading one and derive the shift count directly.
    task automatic model(input logic [31:0] av, input logic m,
                         output logic [31:0] v, output int n, output logic dl, output logic st);
        int p;
        p  = -1;
        for (int i = 0; i < WIDTH; i++) if (av[i]) p = i;
        v  = av;
        n  = 0;
        dl = 1'b0;
        st = 1'b0;
        if (p >= FIELD) begin
            n = p - FIELD + 1;
            v = av >> n;
            for (int i = 0; i < n; i++) st = st | av[i];
        end else if (m && p >= 0 && p < FIELD - 1) begin
            n  = FIELD - 1 - p;
            v  = av << n;
            dl = 1'b1;
        end
`ifndef NORM_STICKY_EN
        st = 1'b0;
`endif
    endtask

    task automatic run_op(input logic [31:0] av, input logic m, input int hold);
        logic [31:0] ev;
        int          en;
        logic        edl, est;
        int          lat;
        logic        got;
        model(av, m, ev, en, edl, est);
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = av;
        bus.mode  = m;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.a     = $urandom;
        bus.mode  = 1'($urandom);
        check("in_ready_low_after_accept", bus.in_ready, 1'b0);
        lat = 0;
        got = 1'b0;
        for (int e = 1; e <= 2 * WIDTH && !got; e++) begin
            @(posedge clk);
            #1;
            if (bus.out_valid) begin
                got = 1'b1;
                lat = e;
            end
        end
        check("done_reached", got, 1'b1);
        check("latency", lat, en + 1);
        check("value", bus.value, ev);
        check("shift_cnt", bus.shift_cnt, en);
        check("dir_left", bus.dir_left, edl);
        check("zero", bus.zero, (av == 0));
        check("sticky", bus.sticky, est);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            bus.start = 1'($urandom);
            bus.a     = $urandom;
            bus.mode  = 1'($urandom);
            @(posedge clk);
            #1;
            check("hold_valid", bus.out_valid, 1'b1);
            check("hold_value", bus.value, ev);
            check("hold_cnt", bus.shift_cnt, en);
            check("hold_sticky", bus.sticky, est);
        end
        @(negedge clk);
        bus.out_ready = 1'b1;
        bus.start     = 1'b1;
        bus.a         = 32'h1;
        @(posedge clk);
        #1;
        check("exit_in_ready", bus.in_ready, 1'b1);
        check("exit_out_valid", bus.out_valid, 1'b0);
        check("exit_value_unchanged", bus.value, ev);
        bus.out_ready = 1'b0;
        bus.start     = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start     = 1'b0;
        bus.mode      = 1'b0;
        bus.a         = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", bus.in_ready, 1'b1);
        check("rst_out_valid", bus.out_valid, 1'b0);
        check("rst_value", bus.value, 0);
        check("rst_cnt", bus.shift_cnt, 0);
        check("rst_zero", bus.zero, 1'b0);
        check("rst_sticky", bus.sticky, 1'b0);
        rst = 1'b0;

        run_op(32'h00FFFFFF, 1'b0, 0);
        run_op(32'hFFFFFFFF, 1'b0, 0);
        run_op(32'h00000001, 1'b1, 0);
        run_op(32'h00000000, 1'b1, 0);
        run_op(32'h00000000, 1'b0, 0);
        run_op(32'h80000000, 1'b0, 5);
        run_op(32'h00000001, 1'b0, 0);
        run_op(32'h00800000, 1'b1, 1);
        run_op(32'h01000000, 1'b1, 0);

        // Abort mid-operation, with start also asserted on the reset edge.
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 32'hFFFFFFFF;
        bus.mode  = 1'b0;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst       = 1'b1;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        check("abort_in_ready", bus.in_ready, 1'b1);
        check("abort_out_valid", bus.out_valid, 1'b0);
        check("abort_value", bus.value, 0);
        check("abort_cnt", bus.shift_cnt, 0);
        check("abort_dir_left", bus.dir_left, 1'b0);
        check("abort_zero", bus.zero, 1'b0);
        check("abort_sticky", bus.sticky, 1'b0);
        rst       = 1'b0;
        bus.start = 1'b0;
        run_op(32'hFFFFFFFF, 1'b0, 0);

        for (int k = 0; k < 40; k++) begin
            logic [31:0] r;
            r = $urandom >> $urandom_range(0, 31);
            run_op(r, 1'($urandom), int'($urandom_range(0, 2)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
